serial_out_loader: RTL and testbench

//   Sequencer that configures diff_freq_serial_out without a UART host. On start_i it emits one

---
 rtl/serial_out_pkg.sv | 27 ++
 rtl/pace_counter.sv | 30 +++
 rtl/serial_out_loader.sv | 164 ++++++++++++++++
 tb/tb_serial_out_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_out_pkg.sv
// serial_out_pkg: shared constants and FSM encoding for the serial_out_loader sequencer
//   CMD_FREQ / CMD_DATA : packet command bytes
//   OFS_*               : byte offsets inside a packet (byte 0 is sent first)
//   state_e             : sequencer FSM states
package serial_out_pkg;

    localparam logic [7:0] CMD_FREQ = 8'h0A;
    localparam logic [7:0] CMD_DATA = 8'h0B;

    localparam int OFS_CMD  = 0;
    localparam int OFS_WORD = 1;
    localparam int OFS_ARG0 = 5;
    localparam int OFS_ARG1 = 6;
    localparam int OFS_HDR  = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        BGAP,
        PGAP,
        FETCH,
        CAPT,
        DONE
    } state_e;

endpackage

// File: rtl/pace_counter.sv
// pace_counter: loadable down-counter that pauses the sequencer between bytes and packets
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i, val_i : load val_i; the counter then stays expire-free for val_i cycles
//   en_i          : decrement while non-zero
//   expire_o      : count has reached zero
module pace_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign expire_o = cnt_q == '0;

endmodule

// File: rtl/serial_out_loader.sv
// serial_out_loader: emits one FREQ packet then one DATA packet per channel as a paced byte stream
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   start_i, abort_i               : start a sequence when idle / return to idle at once
//   freq_pattern_i, low/high_period_i : FREQ packet payload, latched at start
//   ch_rd_o, ch_addr_o             : channel table read port (data one cycle later)
//   ch_pattern_i, ch_ctrl_i        : channel table word {pattern}, {mode,stop,start}
//   data_o, tx_tick_o              : packet byte and its 1-cycle strobe
//   busy_o, done_tick_o            : sequence running / full sequence sent
module serial_out_loader
    import serial_out_pkg::*;
#(
    parameter int DATA_BIT   = 32,
    parameter int PACK_NUM   = 9,
    parameter int OUTPUT_NUM = 16,
    parameter int BYTE_GAP   = 4,
    parameter int PACK_GAP   = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [DATA_BIT-1:0] freq_pattern_i,
    input  logic [7:0]          low_period_i,
    input  logic [7:0]          high_period_i,
    output logic                ch_rd_o,
    output logic [3:0]          ch_addr_o,
    input  logic [DATA_BIT-1:0] ch_pattern_i,
    input  logic [2:0]          ch_ctrl_i,
    output logic [7:0]          data_o,
    output logic                tx_tick_o,
    output logic                busy_o,
    output logic                done_tick_o
);

    localparam int PW = PACK_NUM * 8;
    // SEND itself is one of the gap cycles, and FETCH+CAPT take two more before the next SEND;
    // the final packet has no FETCH/CAPT, so its gap is one cycle longer to land DONE on time.
    localparam logic [7:0] BG_LD  = 8'(BYTE_GAP - 2);
    localparam logic [7:0] PG_MID = 8'(PACK_GAP - 4);
    localparam logic [7:0] PG_END = 8'(PACK_GAP - 3);

    state_e                state_q;
    logic [DATA_BIT-1:0]   freq_q;
    logic [7:0]            low_q, high_q;
    logic [PW-1:0]         buf_q, freq_pkt, data_pkt;
    logic [3:0]            byte_idx_q;
    logic [4:0]            ch_idx_q;
    logic [7:0]            data_q;
    logic                  tx_tick_q, busy_q, done_q, ch_rd_q;
    logic [3:0]            ch_addr_q;
    logic                  last_byte, all_sent, gap_exp;
    logic [7:0]            gap_val;

    assign last_byte = byte_idx_q == 4'(PACK_NUM - 1);
    assign all_sent  = ch_idx_q == 5'(OUTPUT_NUM);
    assign gap_val   = !last_byte ? BG_LD : all_sent ? PG_END : PG_MID;

    always_comb begin
        freq_pkt = '0;
        freq_pkt[PW-1 -: OFS_HDR*8] = {CMD_FREQ, freq_q, low_q, high_q};
        data_pkt = '0;
        data_pkt[PW-1 -: OFS_HDR*8] = {CMD_DATA, ch_pattern_i, 4'h0, ch_idx_q[3:0], 5'h0, ch_ctrl_i};
    end

    pace_counter #(.W(8)) u_pace (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (state_q == SEND),
        .en_i    (state_q == BGAP || state_q == PGAP),
        .val_i   (gap_val),
        .expire_o(gap_exp)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            freq_q     <= '0;
            low_q      <= '0;
            high_q     <= '0;
            buf_q      <= '0;
            byte_idx_q <= '0;
            ch_idx_q   <= '0;
            data_q     <= '0;
            tx_tick_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ch_rd_q    <= 1'b0;
            ch_addr_q  <= '0;
        end else begin
            tx_tick_q <= 1'b0;
            done_q    <= 1'b0;
            ch_rd_q   <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start_i) begin
                        freq_q     <= freq_pattern_i;
                        low_q      <= low_period_i;
                        high_q     <= high_period_i;
                        byte_idx_q <= '0;
                        ch_idx_q   <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end
                    LOAD: begin
                        data_q    <= freq_pkt[PW-1 -: 8];
                        buf_q     <= freq_pkt << 8;
                        tx_tick_q <= 1'b1;
                        state_q   <= SEND;
                    end
                    SEND: begin
                        byte_idx_q <= last_byte ? 4'd0 : byte_idx_q + 4'd1;
                        if (!last_byte) state_q <= BGAP;
                        else if (all_sent || PACK_GAP > 3) state_q <= PGAP;
                        else begin
                            ch_rd_q   <= 1'b1;
                            ch_addr_q <= ch_idx_q[3:0];
                            state_q   <= FETCH;
                        end
                    end
                    BGAP: if (gap_exp) begin
                        data_q    <= buf_q[PW-1 -: 8];
                        buf_q     <= buf_q << 8;
                        tx_tick_q <= 1'b1;
                        state_q   <= SEND;
                    end
                    PGAP: if (gap_exp) begin
                        if (all_sent) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            ch_rd_q   <= 1'b1;
                            ch_addr_q <= ch_idx_q[3:0];
                            state_q   <= FETCH;
                        end
                    end
                    FETCH: state_q <= CAPT;
                    CAPT: begin
                        data_q    <= data_pkt[PW-1 -: 8];
                        buf_q     <= data_pkt << 8;
                        ch_idx_q  <= ch_idx_q + 5'd1;
                        tx_tick_q <= 1'b1;
                        state_q   <= SEND;
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_o      = data_q;
    assign tx_tick_o   = tx_tick_q;
    assign busy_o      = busy_q;
    assign done_tick_o = done_q;
    assign ch_rd_o     = ch_rd_q;
    assign ch_addr_o   = ch_addr_q;

endmodule

// File: tb/tb_serial_out_loader.sv
// tb_serial_out_loader: directed bench for serial_out_loader with a 1-cycle channel table model
module tb_serial_out_loader;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] freq_pattern_i = '0;
    logic [7:0]  low_period_i = '0;
    logic [7:0]  high_period_i = '0;
    logic        ch_rd_o;
    logic [3:0]  ch_addr_o;
    logic [31:0] ch_pattern_i = '0;
    logic [2:0]  ch_ctrl_i = '0;
    logic [7:0]  data_o;
    logic        tx_tick_o;
    logic        busy_o;
    logic        done_tick_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] bytes_q[$];
    int tcyc_q[$];
    int done_n = 0;
    int done_cyc = 0;

    serial_out_loader dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .freq_pattern_i(freq_pattern_i),
        .low_period_i  (low_period_i),
        .high_period_i (high_period_i),
        .ch_rd_o       (ch_rd_o),
        .ch_addr_o     (ch_addr_o),
        .ch_pattern_i  (ch_pattern_i),
        .ch_ctrl_i     (ch_ctrl_i),
        .data_o        (data_o),
        .tx_tick_o     (tx_tick_o),
        .busy_o        (busy_o),
        .done_tick_o   (done_tick_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (ch_rd_o) begin
        ch_pattern_i <= 32'hA5A5_0000 + {28'h0, ch_addr_o};
        ch_ctrl_i    <= 3'b001;
    end

    always @(posedge clk) begin
        #1;
        if (tx_tick_o) begin
            bytes_q.push_back(data_o);
            tcyc_q.push_back(cyc);
        end
        if (done_tick_o) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
        end
    end

    function automatic logic [71:0] exp_pkt(int p, logic [31:0] f, logic [7:0] lo, logic [7:0] hi);
        logic [31:0] w;
        w = 32'hA5A5_0000 + 32'(p - 1);
        if (p == 0) return {8'h0A, f, lo, hi, 16'h0000};
        return {8'h0B, w, 4'h0, 4'(p - 1), 8'h01, 16'h0000};
    endfunction

    function automatic int stream_bad(logic [31:0] f, logic [7:0] lo, logic [7:0] hi);
        int bad = 0;
        logic [71:0] pk;
        for (int i = 0; i < bytes_q.size(); i++) begin
            pk = exp_pkt(i / 9, f, lo, hi);
            if (bytes_q[i] !== pk[8*(8 - i % 9) +: 8]) bad++;
        end
        return bad;
    endfunction

    function automatic int spacing_bad();
        int bad = 0;
        for (int i = 1; i < tcyc_q.size(); i++)
            if (tcyc_q[i] - tcyc_q[i-1] != ((i % 9 == 0) ? 8 : 4)) bad++;
        return bad;
    endfunction

    function automatic logic [71:0] pkt_at(int p);
        logic [71:0] r = '0;
        for (int i = 0; i < 9; i++) r = {r[63:0], bytes_q[p*9 + i]};
        return r;
    endfunction

    task automatic clear_mon();
        bytes_q.delete();
        tcyc_q.delete();
        done_n = 0;
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        start_i = 1'b1;
        s = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (done_tick_o) got = 1'b1;
        end
    endtask

    task automatic wait_ticks(input int n, output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (bytes_q.size() >= n) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({busy_o, tx_tick_o, done_tick_o, ch_rd_o, ch_addr_o, data_o} !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold: outputs %h expected 0000", {busy_o, tx_tick_o, done_tick_o, ch_rd_o, ch_addr_o, data_o});
        end
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, tx_tick_o, done_tick_o, ch_rd_o, ch_addr_o, data_o} !== 16'h0 || bytes_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: outputs %h ticks %0d expected 0000 / 0", {busy_o, tx_tick_o, done_tick_o, ch_rd_o, ch_addr_o, data_o}, bytes_q.size());
        end
    endtask

    task automatic test_stream();
        int s;
        bit got;
        clear_mon();
        freq_pattern_i = 32'hF0F0_0F0F;
        low_period_i   = 8'd9;
        high_period_i  = 8'd3;
        pulse_start(s);
        wait_done(got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL stream_done_timeout: done_tick_o never seen");
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_done: busy_o %b expected 1", busy_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done: busy_o %b expected 0", busy_o);
        end
        checks++;
        if (bytes_q.size() != 153) begin
            errors++;
            $display("FAIL tick_count: got %0d expected 153", bytes_q.size());
        end
        if (bytes_q.size() == 153) begin
            checks++;
            if (pkt_at(0) !== 72'h0A_F0F00F0F_09_03_0000) begin
                errors++;
                $display("FAIL freq_packet: got %h expected 0af0f00f0f09030000", pkt_at(0));
            end
            checks++;
            if (pkt_at(16) !== 72'h0B_A5A5000F_0F_01_0000) begin
                errors++;
                $display("FAIL ch15_packet: got %h expected 0ba5a5000f0f010000", pkt_at(16));
            end
            checks++;
            if (tcyc_q[0] - s != 2) begin
                errors++;
                $display("FAIL first_tick: got cycle %0d expected 2", tcyc_q[0] - s);
            end
            checks++;
            if (done_cyc - tcyc_q[152] != 7) begin
                errors++;
                $display("FAIL done_delay: got %0d expected 7", done_cyc - tcyc_q[152]);
            end
        end
        checks++;
        if (stream_bad(32'hF0F0_0F0F, 8'd9, 8'd3) != 0) begin
            errors++;
            $display("FAIL stream_bytes: %0d bytes differ expected 0", stream_bad(32'hF0F0_0F0F, 8'd9, 8'd3));
        end
        checks++;
        if (spacing_bad() != 0) begin
            errors++;
            $display("FAIL tick_spacing: %0d gaps wrong expected 0", spacing_bad());
        end
        checks++;
        if (done_n != 1) begin
            errors++;
            $display("FAIL done_count: got %0d expected 1", done_n);
        end
    endtask

    task automatic test_latch();
        int s;
        bit got;
        clear_mon();
        freq_pattern_i = 32'h1234_5678;
        low_period_i   = 8'h22;
        high_period_i  = 8'h11;
        pulse_start(s);
        freq_pattern_i = 32'h0;
        low_period_i   = 8'hFF;
        high_period_i  = 8'hEE;
        wait_done(got);
        checks++;
        if (!got || bytes_q.size() != 153 || pkt_at(0) !== 72'h0A_12345678_22_11_0000) begin
            errors++;
            $display("FAIL latch_freq: done %b ticks %0d first packet %h expected 0a1234567822110000", got, bytes_q.size(), bytes_q.size() >= 9 ? pkt_at(0) : 72'h0);
        end
        checks++;
        if (stream_bad(32'h1234_5678, 8'h22, 8'h11) != 0) begin
            errors++;
            $display("FAIL latch_stream: %0d bytes differ expected 0", stream_bad(32'h1234_5678, 8'h22, 8'h11));
        end
    endtask

    task automatic test_start_ignored();
        int s;
        bit got;
        clear_mon();
        freq_pattern_i = 32'hF0F0_0F0F;
        low_period_i   = 8'd9;
        high_period_i  = 8'd3;
        pulse_start(s);
        wait_ticks(45, got);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(got);
        repeat (40) @(negedge clk);
        checks++;
        if (!got || bytes_q.size() != 153) begin
            errors++;
            $display("FAIL restart_count: done %b ticks %0d expected 1 / 153", got, bytes_q.size());
        end
        checks++;
        if (stream_bad(32'hF0F0_0F0F, 8'd9, 8'd3) != 0 || spacing_bad() != 0) begin
            errors++;
            $display("FAIL restart_stream: %0d bytes %0d gaps differ expected 0", stream_bad(32'hF0F0_0F0F, 8'd9, 8'd3), spacing_bad());
        end
        checks++;
        if (done_n != 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_done: done_n %0d busy %b expected 1 / 0", done_n, busy_o);
        end
    endtask

    task automatic test_abort();
        int s;
        int n;
        bit got;
        clear_mon();
        pulse_start(s);
        wait_ticks(28, got);
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || tx_tick_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy %b tick %b expected 0 / 0", busy_o, tx_tick_o);
        end
        n = bytes_q.size();
        repeat (60) @(negedge clk);
        checks++;
        if (bytes_q.size() != 28 || n != 28) begin
            errors++;
            $display("FAIL abort_ticks: got %0d then %0d expected 28", n, bytes_q.size());
        end
        checks++;
        if (done_n != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: done_n %0d busy %b expected 0 / 0", done_n, busy_o);
        end
        clear_mon();
        pulse_start(s);
        wait_done(got);
        checks++;
        if (!got || bytes_q.size() != 153 || stream_bad(32'hF0F0_0F0F, 8'd9, 8'd3) != 0) begin
            errors++;
            $display("FAIL abort_rerun: done %b ticks %0d bad %0d expected 1 / 153 / 0", got, bytes_q.size(), stream_bad(32'hF0F0_0F0F, 8'd9, 8'd3));
        end
        checks++;
        if (tcyc_q.size() == 0 || tcyc_q[0] - s != 2 || spacing_bad() != 0) begin
            errors++;
            $display("FAIL abort_rerun_timing: first %0d gaps bad %0d expected 2 / 0", tcyc_q.size() ? tcyc_q[0] - s : -1, spacing_bad());
        end
    endtask

    task automatic test_reset_mid();
        int s;
        bit got;
        clear_mon();
        pulse_start(s);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (ch_rd_o && ch_addr_o == 4'd2) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL fetch_timeout: ch_rd_o for channel 2 never seen");
        end
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, tx_tick_o, done_tick_o, ch_rd_o, ch_addr_o, data_o} !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: outputs %h expected 0000", {busy_o, tx_tick_o, done_tick_o, ch_rd_o, ch_addr_o, data_o});
        end
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        clear_mon();
        repeat (30) @(negedge clk);
        checks++;
        if (bytes_q.size() != 0 || busy_o !== 1'b0 || done_n != 0) begin
            errors++;
            $display("FAIL post_reset_idle: ticks %0d busy %b done %0d expected 0", bytes_q.size(), busy_o, done_n);
        end
        pulse_start(s);
        wait_done(got);
        checks++;
        if (!got || bytes_q.size() != 153 || stream_bad(32'hF0F0_0F0F, 8'd9, 8'd3) != 0) begin
            errors++;
            $display("FAIL post_reset_run: done %b ticks %0d bad %0d expected 1 / 153 / 0", got, bytes_q.size(), stream_bad(32'hF0F0_0F0F, 8'd9, 8'd3));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_latch();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
